// File: rtl/spi_reg_ctrl.sv
// rtl/spi_reg_ctrl.sv - SPI command/register controller with auto-incrementing register bank
module spi_reg_ctrl #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    ADDR_WIDTH = 4,
    parameter logic                  CE_LEVEL   = 1'b0,
    parameter logic [DATA_WIDTH-1:0] IDLE_BYTE  = 8'hA5
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic                                  ce,
    input  logic [DATA_WIDTH-1:0]                 rx_data,
    input  logic                                  spi_done,
    output logic [DATA_WIDTH-1:0]                 tx_data,
    output logic [(2**ADDR_WIDTH)*DATA_WIDTH-1:0] reg_out,
    output logic                                  wr_pulse,
    output logic [ADDR_WIDTH-1:0]                 wr_addr,
    output logic [DATA_WIDTH-1:0]                 wr_data,
    output logic                                  frame_active
);

    localparam int NUM_REGS = 2**ADDR_WIDTH;

    typedef enum logic [1:0] {IDLE, CMD, WR_DATA, RD_DATA} state_t;

    state_t                state;
    state_t                state_nxt;
    logic                  ce_meta;
    logic                  ce_sync;
    logic                  cs_act;
    logic                  armed;
    logic [ADDR_WIDTH-1:0] ptr;
    logic [ADDR_WIDTH-1:0] ptr_inc;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic                  cmd_is_wr;
    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    assign cs_act       = (ce_sync == CE_LEVEL);
    assign ptr_inc      = ptr + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    assign cmd_addr     = rx_data[ADDR_WIDTH-1:0];
    assign cmd_is_wr    = rx_data[DATA_WIDTH-1];
    assign frame_active = (state != IDLE);

    // Two-stage ce synchroniser; resets to the active level so a chip select
    // held active across reset is seen as "still active" and never re-arms.
    always_ff @(posedge clock) begin
        if (reset) begin
            ce_meta <= CE_LEVEL;
            ce_sync <= CE_LEVEL;
        end else begin
            ce_meta <= ce;
            ce_sync <= ce_meta;
        end
    end

    // A new frame may only start after chip select has been seen inactive since reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            armed <= 1'b0;
        end else if (!cs_act) begin
            armed <= 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; chip select going inactive wins after the byte is processed.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cs_act && armed) state_nxt = CMD;
            CMD:     if (spi_done) state_nxt = cmd_is_wr ? WR_DATA : RD_DATA;
            default: state_nxt = state;
        endcase
        if (!cs_act) begin
            state_nxt = IDLE;
        end
    end

    // Register bank, address pointer, write strobe and read-back byte.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            ptr      <= '0;
            tx_data  <= IDLE_BYTE;
            wr_pulse <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
        end else begin
            wr_pulse <= 1'b0;
            if (state == CMD && spi_done) begin
                ptr <= cmd_addr;
                if (!cmd_is_wr) begin
                    tx_data <= regs[cmd_addr];
                end
            end
            if (state == WR_DATA && spi_done) begin
                regs[ptr] <= rx_data;
                wr_pulse  <= 1'b1;
                wr_addr   <= ptr;
                wr_data   <= rx_data;
                ptr       <= ptr_inc;
            end
            if (state == RD_DATA && spi_done) begin
                ptr     <= ptr_inc;
                tx_data <= regs[ptr_inc];
            end
            if (state_nxt == IDLE) begin
                tx_data <= IDLE_BYTE;
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_REGS; g++) begin : g_flat
            assign reg_out[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
        end
    endgenerate

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// tb/tb_spi_reg_ctrl.sv - self-checking bench for spi_reg_ctrl
module tb_spi_reg_ctrl;

    localparam int          DW        = 8;
    localparam int          AW        = 4;
    localparam int          NR        = 16;
    localparam logic        CE_LEVEL  = 1'b0;
    localparam logic [7:0]  IDLE_BYTE = 8'hA5;

    logic            clock    = 1'b0;
    logic            reset    = 1'b1;
    logic            ce       = 1'b1;
    logic [DW-1:0]   rx_data  = '0;
    logic            spi_done = 1'b0;
    logic [DW-1:0]   tx_data;
    logic [NR*DW-1:0] reg_out;
    logic            wr_pulse;
    logic [AW-1:0]   wr_addr;
    logic [DW-1:0]   wr_data;
    logic            frame_active;

    spi_reg_ctrl #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CE_LEVEL(CE_LEVEL), .IDLE_BYTE(IDLE_BYTE)
    ) dut (
        .clock(clock), .reset(reset), .ce(ce), .rx_data(rx_data), .spi_done(spi_done),
        .tx_data(tx_data), .reg_out(reg_out), .wr_pulse(wr_pulse), .wr_addr(wr_addr),
        .wr_data(wr_data), .frame_active(frame_active)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad = 0;
    int pulse_cnt = 0;
    logic [7:0] model [NR];
    logic [7:0] fr_data [8];
    logic [7:0] rec [8];

    always @(negedge clock) if (wr_pulse === 1'b1) pulse_cnt++;

    typedef struct {
        logic [7:0] cmd;
        logic [7:0] d0;
        logic [7:0] d1;
        logic [7:0] e0;
        logic [7:0] e1;
    } vec_t;

    vec_t vecs [4];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] model_flat();
        logic [127:0] f;
        for (int i = 0; i < NR; i++) f[i*8 +: 8] = model[i];
        return f;
    endfunction

    task automatic ce_on();
        ce = CE_LEVEL;
        repeat (4) @(posedge clock);
        #1;
    endtask

    task automatic ce_off();
        ce = ~CE_LEVEL;
        repeat (4) @(posedge clock);
        @(negedge clock);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic [7:0] tx, output logic p,
                             output logic [3:0] wa, output logic [7:0] wd, output logic pn);
        @(posedge clock); #1;
        rx_data  = b;
        spi_done = 1'b1;
        @(posedge clock); #1;
        spi_done = 1'b0;
        @(negedge clock);
        tx = tx_data; p = wr_pulse; wa = wr_addr; wd = wr_data;
        @(negedge clock);
        pn = wr_pulse;
    endtask

    task automatic run_frame(input logic [7:0] cmd, input int n);
        logic [7:0] tx, wd;
        logic [3:0] wa, ptr;
        logic p, pn, is_wr;
        int pc0;
        is_wr = cmd[7];
        ptr   = cmd[3:0];
        pc0   = pulse_cnt;
        ce_on();
        chk("frame_active_on", frame_active, 1);
        send_byte(cmd, tx, p, wa, wd, pn);
        chk("cmd_no_pulse", p, 0);
        if (is_wr) chk("wr_cmd_tx", tx, IDLE_BYTE);
        else begin
            chk("rd_first_tx", tx, model[ptr]);
            rec[0] = tx;
        end
        for (int i = 0; i < n; i++) begin
            send_byte(fr_data[i], tx, p, wa, wd, pn);
            if (is_wr) begin
                chk("wr_pulse", p, 1);
                chk("wr_addr", wa, ptr);
                chk("wr_data", wd, fr_data[i]);
                chk("wr_pulse_len", pn, 0);
                chk("wr_tx_idle", tx, IDLE_BYTE);
                model[ptr] = fr_data[i];
                rec[i] = wd;
            end else begin
                chk("rd_no_pulse", p, 0);
            end
            ptr = ptr + 4'd1;
            if (!is_wr) begin
                chk("rd_tx", tx, model[ptr]);
                rec[i+1] = tx;
            end
        end
        ce_off();
        chk("tx_idle_after", tx_data, IDLE_BYTE);
        chk("frame_inactive", frame_active, 0);
        chk("reg_out", reg_out, model_flat());
        chk("pulse_count", pulse_cnt - pc0, is_wr ? n : 0);
    endtask

    initial begin
        logic [7:0] tx, wd;
        logic [3:0] wa;
        logic p, pn;
        int cyc;

        vecs[0] = '{cmd: 8'h83, d0: 8'h11, d1: 8'h22, e0: 8'h11, e1: 8'h22};
        vecs[1] = '{cmd: 8'h03, d0: 8'h00, d1: 8'h00, e0: 8'h11, e1: 8'h22};
        vecs[2] = '{cmd: 8'h8F, d0: 8'hAA, d1: 8'hBB, e0: 8'hAA, e1: 8'hBB};
        vecs[3] = '{cmd: 8'h0F, d0: 8'hFF, d1: 8'h5C, e0: 8'hAA, e1: 8'hBB};
        for (int i = 0; i < NR; i++) model[i] = 8'h00;

        // reset and idle
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("rst_reg_out", reg_out, 0);
        chk("rst_tx", tx_data, IDLE_BYTE);
        chk("rst_frame_active", frame_active, 0);
        chk("rst_wr_pulse", wr_pulse, 0);
        repeat (10) @(negedge clock);
        chk("idle_no_pulse", pulse_cnt, 0);
        chk("idle_frame_active", frame_active, 0);

        // table-driven directed frames
        for (int v = 0; v < 4; v++) begin
            fr_data[0] = vecs[v].d0;
            fr_data[1] = vecs[v].d1;
            run_frame(vecs[v].cmd, 2);
            chk("vec_e0", rec[0], vecs[v].e0);
            chk("vec_e1", rec[1], vecs[v].e1);
        end
        chk("wrap_reg15", reg_out[15*8 +: 8], 8'hAA);
        chk("wrap_reg0", reg_out[0 +: 8], 8'hBB);
        chk("reg3", reg_out[3*8 +: 8], 8'h11);
        chk("reg4", reg_out[4*8 +: 8], 8'h22);

        // ce drops in the same cycle as a data spi_done
        ce_on();
        send_byte(8'h85, tx, p, wa, wd, pn);
        @(posedge clock); #1;
        rx_data = 8'h5A; spi_done = 1'b1; ce = ~CE_LEVEL;
        @(posedge clock); #1;
        spi_done = 1'b0;
        @(negedge clock);
        chk("drop_wr_pulse", wr_pulse, 1);
        chk("drop_wr_addr", wr_addr, 5);
        chk("drop_wr_data", wr_data, 8'h5A);
        model[5] = 8'h5A;
        cyc = 1;
        while (frame_active === 1'b1 && cyc < 3) begin
            @(negedge clock);
            cyc++;
        end
        chk("drop_frame_active", frame_active, 0);
        repeat (3) @(negedge clock);
        chk("drop_reg_out", reg_out, model_flat());
        chk("drop_tx", tx_data, IDLE_BYTE);

        // randomized frames against the reference model
        for (int f = 0; f < 40; f++) begin
            int n;
            n = $urandom_range(0, 5);
            for (int i = 0; i < n; i++) fr_data[i] = 8'($urandom);
            run_frame(8'($urandom), n);
        end

        // reset after the command byte of a write frame, ce held active
        ce_on();
        send_byte(8'h82, tx, p, wa, wd, pn);
        @(posedge clock); #1 reset = 1'b1;
        @(posedge clock); #1 reset = 1'b0;
        for (int i = 0; i < NR; i++) model[i] = 8'h00;
        @(negedge clock);
        chk("mid_rst_reg_out", reg_out, 0);
        chk("mid_rst_frame_active", frame_active, 0);
        chk("mid_rst_tx", tx_data, IDLE_BYTE);
        send_byte(8'h77, tx, p, wa, wd, pn);
        chk("mid_rst_no_pulse", p, 0);
        chk("mid_rst_no_write", reg_out, 0);
        repeat (6) @(negedge clock);
        chk("mid_rst_stay_idle", frame_active, 0);
        ce_off();
        fr_data[0] = 8'h00;
        run_frame(8'h02, 1);
        chk("post_rst_read", rec[0], 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
